// File: rtl/lfa_nav_controller.sv
// Line-follow / node / turn controller for the 3-sensor LFA bot, driving two H-bridges and PWM duties.
// Build option LOST_RECOVERY_EN: LOST spins toward the last correction side instead of stopping at once.
module lfa_nav_controller #(
  parameter int SENS_W    = 12,
  parameter int HI_TH     = 1000,
  parameter int LO_TH     = 250,
  parameter int DUTY_W    = 5,
  parameter int FWD_DUTY  = 16,
  parameter int CORR_FAST = 20,
  parameter int CORR_SLOW = 10,
  parameter int TURN_DUTY = 20,
  parameter int NODE_DEB  = 8,
  parameter int MIN_TURN  = 500,
  parameter int TURN_TMO  = 4000
) (
  input  logic              clk_3125KHz,
  input  logic              reset,
  input  logic              start,
  input  logic [SENS_W-1:0] left,
  input  logic [SENS_W-1:0] middle,
  input  logic [SENS_W-1:0] right,
  input  logic [1:0]        turn_cmd,
  input  logic              turn_valid,
  output logic              turn_ready,
  input  logic              end_path,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [DUTY_W-1:0] dc1,
  output logic [DUTY_W-1:0] dc2,
  output logic              node_flag,
  output logic              node_pulse,
  output logic [2:0]        state_o
);
  localparam int MAXD = (1 << DUTY_W) - 1;
  localparam int TW   = $clog2(TURN_TMO + 1);
  localparam int BW   = $clog2(NODE_DEB + 1);
  localparam int MW   = 4 + 2 * DUTY_W;

  if (HI_TH <= LO_TH || HI_TH >= (1 << SENS_W) || NODE_DEB < 1 ||
      MIN_TURN < 1 || MIN_TURN >= TURN_TMO || DUTY_W < 1) begin : g_param_err
    $error("lfa_nav_controller: illegal parameter combination");
  end

  function automatic logic [DUTY_W-1:0] sat(input int v);
    return (v > MAXD) ? DUTY_W'(MAXD) : DUTY_W'(v);
  endfunction

  localparam logic [DUTY_W-1:0] FWD_D  = sat(FWD_DUTY);
  localparam logic [DUTY_W-1:0] FAST_D = sat(CORR_FAST);
  localparam logic [DUTY_W-1:0] SLOW_D = sat(CORR_SLOW);
  localparam logic [DUTY_W-1:0] TURN_D = sat(TURN_DUTY);
  localparam logic [SENS_W-1:0] HI_V   = SENS_W'(HI_TH);
  localparam logic [SENS_W-1:0] LO_V   = SENS_W'(LO_TH);
  localparam logic [TW-1:0]     TMO_M1 = TW'(TURN_TMO - 1);
  localparam logic [TW-1:0]     MIN_V  = TW'(MIN_TURN);
  localparam logic [BW-1:0]     DEB_M1 = BW'(NODE_DEB - 1);

  typedef enum logic [2:0] {S_IDLE = 3'd0, S_FOLLOW = 3'd1, S_NODE = 3'd2,
                            S_TURN = 3'd3, S_LOST = 3'd4} state_t;
  typedef enum logic [1:0] {CL_W, CL_G, CL_B} cls_t;

  function automatic cls_t classify(input logic [SENS_W-1:0] s);
    if (s > HI_V) return CL_B;
    if (s < LO_V) return CL_W;
    return CL_G;
  endfunction

  // packed motor command: {m1_a, m1_b, m2_a, m2_b, dc1, dc2}
  function automatic logic [MW-1:0] drive(input logic l_fwd, input logic r_fwd,
                                          input logic [DUTY_W-1:0] dl, input logic [DUTY_W-1:0] dr);
    return {l_fwd, ~l_fwd, r_fwd, ~r_fwd, dl, dr};
  endfunction

  state_t          state_q, state_d;
  logic [MW-1:0]   mot_q, mot_d, lost_mot;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            reacq_q, reacq_d, ready_q, ready_d, pulse_q, pulse_d;
  cls_t            cl, cm, cr;
  logic            straight, corr_l, corr_r, all_b, all_w;
`ifdef LOST_RECOVERY_EN
  logic            last_q, last_d, stop_q, stop_d;
`endif

  always_comb begin
    cl       = classify(left);
    cm       = classify(middle);
    cr       = classify(right);
    straight = (cl == CL_W) && (cm == CL_B) && (cr == CL_W);
    corr_l   = (cl == CL_B) && (cr == CL_W);
    corr_r   = (cr == CL_B) && (cl == CL_W);
    all_b    = (cl == CL_B) && (cm == CL_B) && (cr == CL_B);
    all_w    = (cl == CL_W) && (cm == CL_W) && (cr == CL_W);
  end

`ifdef LOST_RECOVERY_EN
  always_comb begin
    last_d = last_q;
    if (state_q == S_FOLLOW && corr_r) last_d = 1'b1;
    else if (state_q == S_FOLLOW && corr_l) last_d = 1'b0;
    lost_mot = last_q ? drive(1'b1, 1'b0, SLOW_D, SLOW_D) : drive(1'b0, 1'b1, SLOW_D, SLOW_D);
  end
`else
  assign lost_mot = '0;
`endif

  always_comb begin
    state_d = state_q;
    mot_d   = mot_q;
    tmr_d   = tmr_q;
    blk_d   = blk_q;
    cmd_d   = cmd_q;
    reacq_d = reacq_q;
    ready_d = 1'b0;
    pulse_d = 1'b0;
`ifdef LOST_RECOVERY_EN
    stop_d  = stop_q;
`endif
    case (state_q)
      S_IDLE: begin
        mot_d = '0;
        tmr_d = '0;
        blk_d = '0;
        if (start) state_d = S_FOLLOW;
      end
      S_FOLLOW: begin
        if (straight)    mot_d = drive(1'b1, 1'b1, FWD_D, FWD_D);
        else if (corr_r) mot_d = drive(1'b1, 1'b0, FAST_D, SLOW_D);
        else if (corr_l) mot_d = drive(1'b0, 1'b1, SLOW_D, FAST_D);
        blk_d = all_b ? blk_q + 1'b1 : '0;
        tmr_d = all_w ? tmr_q + 1'b1 : '0;
        // node debounce wins over the all-white timeout
        if (all_b && blk_q == DEB_M1) begin
          state_d = S_NODE;
          pulse_d = 1'b1;
          ready_d = 1'b1;
          mot_d   = '0;
          blk_d   = '0;
        end else if (all_w && tmr_q == TMO_M1) begin
          state_d = S_LOST;
          tmr_d   = '0;
          mot_d   = lost_mot;
        end
      end
      S_NODE: begin
        mot_d   = '0;
        ready_d = ready_q;
        if (end_path) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end else if (turn_valid && ready_q) begin
          cmd_d   = turn_cmd;
          ready_d = 1'b0;
          tmr_d   = '0;
          reacq_d = 1'b0;
          if (turn_cmd == 2'd0)      state_d = S_FOLLOW;
          else begin
            state_d = S_TURN;
            mot_d   = (turn_cmd == 2'd3) ? drive(1'b0, 1'b1, TURN_D, TURN_D)
                                         : drive(1'b1, 1'b0, TURN_D, TURN_D);
          end
        end
      end
      S_TURN: begin
        tmr_d = tmr_q + 1'b1;
        // a U-turn passes the line once before the real re-acquisition
        if (straight && tmr_q >= MIN_V) begin
          tmr_d = '0;
          if (cmd_q == 2'd2 && !reacq_q) reacq_d = 1'b1;
          else begin
            state_d = S_FOLLOW;
            mot_d   = drive(1'b1, 1'b1, FWD_D, FWD_D);
          end
        end else if (tmr_q == TMO_M1) begin
          state_d = S_LOST;
          tmr_d   = '0;
          mot_d   = lost_mot;
        end
      end
      S_LOST: begin
`ifdef LOST_RECOVERY_EN
        if (start) begin
          state_d = S_FOLLOW;
          mot_d   = '0;
          tmr_d   = '0;
          blk_d   = '0;
          stop_d  = 1'b0;
        end else if (!stop_q) begin
          tmr_d = tmr_q + 1'b1;
          if (straight) begin
            state_d = S_FOLLOW;
            mot_d   = drive(1'b1, 1'b1, FWD_D, FWD_D);
            tmr_d   = '0;
          end else if (tmr_q == TMO_M1) begin
            stop_d = 1'b1;
            mot_d  = '0;
            tmr_d  = '0;
          end
        end
`else
        mot_d = '0;
        if (start) begin
          state_d = S_FOLLOW;
          tmr_d   = '0;
          blk_d   = '0;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        mot_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mot_q   <= '0;
      tmr_q   <= '0;
      blk_q   <= '0;
      cmd_q   <= '0;
      reacq_q <= 1'b0;
      ready_q <= 1'b0;
      pulse_q <= 1'b0;
`ifdef LOST_RECOVERY_EN
      last_q  <= 1'b0;
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mot_q   <= mot_d;
      tmr_q   <= tmr_d;
      blk_q   <= blk_d;
      cmd_q   <= cmd_d;
      reacq_q <= reacq_d;
      ready_q <= ready_d;
      pulse_q <= pulse_d;
`ifdef LOST_RECOVERY_EN
      last_q  <= last_d;
      stop_q  <= stop_d;
`endif
    end
  end

  assign {m1_a, m1_b, m2_a, m2_b, dc1, dc2} = mot_q;
  assign turn_ready = ready_q;
  assign node_pulse = pulse_q;
  assign node_flag  = (state_q == S_NODE) || (state_q == S_TURN);
  assign state_o    = state_q;

endmodule

// File: tb/tb_lfa_nav_controller.sv
// Directed bench for lfa_nav_controller: vector table for follow/debounce, hand sequences for turns, LOST, reset.
module tb_lfa_nav_controller;
  localparam logic [11:0] SW = 12'd100;
  localparam logic [11:0] SB = 12'd2000;
  localparam logic [11:0] SG = 12'd600;
  localparam int NODE_DEB = 8;

  logic        clk_3125KHz = 1'b0;
  logic        reset, start, turn_valid, turn_ready, end_path;
  logic [11:0] left, middle, right;
  logic [1:0]  turn_cmd;
  logic        m1_a, m1_b, m2_a, m2_b, node_flag, node_pulse;
  logic [4:0]  dc1, dc2;
  logic [2:0]  state_o;
  int n_checks = 0;
  int n_errors = 0;

  lfa_nav_controller dut (
    .clk_3125KHz(clk_3125KHz), .reset(reset), .start(start),
    .left(left), .middle(middle), .right(right),
    .turn_cmd(turn_cmd), .turn_valid(turn_valid), .turn_ready(turn_ready), .end_path(end_path),
    .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b),
    .dc1(dc1), .dc2(dc2), .node_flag(node_flag), .node_pulse(node_pulse), .state_o(state_o)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  typedef struct {
    logic        go;
    logic [11:0] l, m, r;
    int          st, mot, d1, d2, pls, rdy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic go, input logic [11:0] l, input logic [11:0] m,
                              input logic [11:0] r, input int st, input int mot,
                              input int d1, input int d2, input int pls, input int rdy);
    vec_t v;
    v.go = go; v.l = l; v.m = m; v.r = r;
    v.st = st; v.mot = mot; v.d1 = d1; v.d2 = d2; v.pls = pls; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_3125KHz);
    @(negedge clk_3125KHz);
  endtask

  task automatic sens(input logic [11:0] l, input logic [11:0] m, input logic [11:0] r);
    left = l; middle = m; right = r;
  endtask

  // mot is {m1_a, m1_b, m2_a, m2_b}
  task automatic chk_out(input string nm, input int st, input int mot, input int d1, input int d2);
    chk({nm, ".state"}, int'(state_o), st);
    chk({nm, ".dir"}, int'({m1_a, m1_b, m2_a, m2_b}), mot);
    chk({nm, ".dc1"}, int'(dc1), d1);
    chk({nm, ".dc2"}, int'(dc2), d2);
  endtask

  task automatic goto_node(input string nm);
    sens(SB, SB, SB);
    repeat (NODE_DEB) tick;
    chk_out(nm, 2, 0, 0, 0);
    chk({nm, ".ready"}, int'(turn_ready), 1);
    chk({nm, ".flag"}, int'(node_flag), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; turn_valid = 1'b0; end_path = 1'b0; turn_cmd = 2'd0;
    sens(12'd0, 12'd0, 12'd0);
    repeat (2) @(negedge clk_3125KHz);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.ready", int'(turn_ready), 0);
    chk("reset.pulse", int'(node_pulse), 0);
    chk("reset.flag", int'(node_flag), 0);
    reset = 1'b0;
    tick;

    vq.push_back(mk(1'b1, SW, SB, SW, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1'b0, SW, SB, SW, 1, 10, 16, 16, 0, 0));
    vq.push_back(mk(1'b0, SB, SG, SW, 1, 6, 10, 20, 0, 0));
    vq.push_back(mk(1'b0, SG, SG, SG, 1, 6, 10, 20, 0, 0));
    vq.push_back(mk(1'b0, SW, SW, SB, 1, 9, 20, 10, 0, 0));
    vq.push_back(mk(1'b1, SW, SB, SW, 1, 10, 16, 16, 0, 0));
    for (int i = 0; i < NODE_DEB - 1; i++) vq.push_back(mk(1'b0, SB, SB, SB, 1, 10, 16, 16, 0, 0));
    vq.push_back(mk(1'b0, SW, SW, SW, 1, 10, 16, 16, 0, 0));
    for (int i = 0; i < NODE_DEB - 1; i++) vq.push_back(mk(1'b0, SB, SB, SB, 1, 10, 16, 16, 0, 0));
    vq.push_back(mk(1'b0, SB, SB, SB, 2, 0, 0, 0, 1, 1));
    vq.push_back(mk(1'b0, SB, SB, SB, 2, 0, 0, 0, 0, 1));

    foreach (vq[i]) begin
      start = vq[i].go;
      sens(vq[i].l, vq[i].m, vq[i].r);
      tick;
      chk_out($sformatf("vec%0d", i), vq[i].st, vq[i].mot, vq[i].d1, vq[i].d2);
      chk($sformatf("vec%0d.pulse", i), int'(node_pulse), vq[i].pls);
      chk($sformatf("vec%0d.ready", i), int'(turn_ready), vq[i].rdy);
    end
    start = 1'b0;

    // left turn: early straight ignored, exact MIN_TURN boundary
    turn_cmd = 2'd3; turn_valid = 1'b1; sens(SW, SW, SW);
    tick;
    turn_valid = 1'b0;
    chk_out("lturn.enter", 3, 6, 20, 20);
    chk("lturn.ready", int'(turn_ready), 0);
    chk("lturn.flag", int'(node_flag), 1);
    repeat (299) tick;
    sens(SW, SB, SW);
    tick;
    chk("lturn.early", int'(state_o), 3);
    sens(SW, SW, SW);
    repeat (199) tick;
    sens(SW, SB, SW);
    tick;
    chk("lturn.min_m1", int'(state_o), 3);
    tick;
    chk_out("lturn.exit", 1, 10, 16, 16);
    chk("lturn.flag_off", int'(node_flag), 0);

    // right turn on white until timeout
    goto_node("node2");
    turn_cmd = 2'd1; turn_valid = 1'b1; sens(SW, SW, SW);
    tick;
    turn_valid = 1'b0;
    chk_out("rturn.enter", 3, 9, 20, 20);
    repeat (3999) tick;
    chk("rturn.pre_tmo", int'(state_o), 3);
    tick;
`ifdef LOST_RECOVERY_EN
    chk_out("lost.spin", 4, 9, 10, 10);
    repeat (3999) tick;
    chk_out("lost.spin_end", 4, 9, 10, 10);
    tick;
    chk_out("lost.stopped", 4, 0, 0, 0);
`else
    chk_out("lost.enter", 4, 0, 0, 0);
    repeat (5) tick;
    chk("lost.hold", int'(state_o), 4);
`endif
    start = 1'b1; sens(SW, SB, SW);
    tick;
    start = 1'b0;
    chk("lost.start", int'(state_o), 1);
    tick;
    chk_out("lost.follow", 1, 10, 16, 16);

    // U-turn needs two re-acquisitions MIN_TURN apart
    goto_node("node3");
    turn_cmd = 2'd2; turn_valid = 1'b1; sens(SW, SB, SW);
    tick;
    turn_valid = 1'b0;
    chk_out("uturn.enter", 3, 9, 20, 20);
    repeat (1001) tick;
    chk("uturn.first_pass", int'(state_o), 3);
    tick;
    chk("uturn.exit", int'(state_o), 1);

    // asynchronous reset in the middle of a turn
    goto_node("node4");
    turn_cmd = 2'd1; turn_valid = 1'b1; sens(SW, SW, SW);
    tick;
    turn_valid = 1'b0;
    repeat (10) tick;
    reset = 1'b1;
    #1;
    chk_out("areset", 0, 0, 0, 0);
    chk("areset.flag", int'(node_flag), 0);
    @(negedge clk_3125KHz);
    reset = 1'b0; start = 1'b1; sens(SW, SB, SW);
    tick;
    start = 1'b0;
    chk("areset.start", int'(state_o), 1);
    tick;

    // end_path beats a valid command
    goto_node("node5");
    end_path = 1'b1; turn_valid = 1'b1; turn_cmd = 2'd1;
    tick;
    end_path = 1'b0; turn_valid = 1'b0;
    chk_out("endpath", 0, 0, 0, 0);
    chk("endpath.ready", int'(turn_ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
